// File: rtl/diff_commit_queue.sv
// Commit-record FIFO between the writeback stage and the difftest checkers.
// Optional DIFF_COMMIT_CNT_EN macro adds a 64-bit emitted-record counter.
module diff_commit_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_pc,
    input  logic [31:0] in_instr,
    input  logic        in_skip,
    input  logic        in_wen,
    input  logic [7:0]  in_wdest,
    input  logic [63:0] in_wdata,
    input  logic [7:0]  in_store_valid,
    input  logic [63:0] in_store_paddr,
    input  logic [63:0] in_store_data,
    input  logic        in_halt,
    input  logic        out_en,
    output logic        out_instr_valid,
    output logic [7:0]  out_index,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_skip,
    output logic        out_wen,
    output logic [7:0]  out_wdest,
    output logic [63:0] out_wdata,
    output logic [7:0]  out_store_valid,
    output logic [63:0] out_store_paddr,
    output logic [63:0] out_store_data,
    output logic        out_halt,
    output logic        out_overflow,
    output logic [63:0] out_commit_cnt
);

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        skip;
        logic        wen;
        logic [7:0]  wdest;
        logic [63:0] wdata;
        logic [7:0]  store_valid;
        logic [63:0] store_paddr;
        logic [63:0] store_data;
        logic        halt;
    } rec_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    localparam logic [PTR_W:0]   CNT_DEPTH = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    state_t           state_reg;
    rec_t             mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic [7:0]       index_reg;

    logic full;
    logic empty;
    logic push;
    logic pop;
    rec_t wr_rec;
    rec_t head;

    assign full     = (count_reg == CNT_DEPTH);
    assign empty    = (count_reg == '0);
    assign in_ready = !full && (state_reg != HALT);
    assign push     = in_valid && in_ready;
    assign pop      = !empty && out_en && (state_reg == RUN);
    assign head     = mem[rd_ptr_reg];

    assign wr_rec = '{pc: in_pc, instr: in_instr, skip: in_skip, wen: in_wen,
                      wdest: in_wdest, wdata: in_wdata, store_valid: in_store_valid,
                      store_paddr: in_store_paddr, store_data: in_store_data,
                      halt: in_halt};

    // Storage has no reset so it can map onto RAM; validity lives in count_reg.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_rec;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= RUN;
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
            count_reg       <= '0;
            index_reg       <= '0;
            out_instr_valid <= 1'b0;
            out_index       <= '0;
            out_pc          <= '0;
            out_instr       <= '0;
            out_skip        <= 1'b0;
            out_wen         <= 1'b0;
            out_wdest       <= '0;
            out_wdata       <= '0;
            out_store_valid <= '0;
            out_store_paddr <= '0;
            out_store_data  <= '0;
            out_halt        <= 1'b0;
            out_overflow    <= 1'b0;
        end else begin
            out_instr_valid <= pop;
            out_store_valid <= pop ? head.store_valid : 8'h00;
            if (in_valid && full) begin
                out_overflow <= 1'b1;
            end
            if (pop) begin
                out_index       <= index_reg;
                index_reg       <= index_reg + 8'd1;
                out_pc          <= head.pc;
                out_instr       <= head.instr;
                out_skip        <= head.skip;
                // A write to x0 never reaches the register-file checker.
                out_wen         <= head.wen && (head.wdest != 8'd0);
                out_wdest       <= head.wdest;
                out_wdata       <= head.wdata;
                out_store_paddr <= head.store_paddr;
                out_store_data  <= head.store_data;
            end
            if (state_reg == RUN) begin
                if (pop && head.halt) begin
                    // Leftover entries (and any same-cycle push) are discarded.
                    state_reg  <= HALT;
                    out_halt   <= 1'b1;
                    rd_ptr_reg <= '0;
                    wr_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push) begin
                        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
                    end
                    if (pop) begin
                        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
                    end
                    if (push && !pop) begin
                        count_reg <= count_reg + CNT_ONE;
                    end else if (pop && !push) begin
                        count_reg <= count_reg - CNT_ONE;
                    end
                end
            end
        end
    end

`ifdef DIFF_COMMIT_CNT_EN
    logic [63:0] commit_cnt_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            commit_cnt_reg <= '0;
        end else if (pop) begin
            commit_cnt_reg <= commit_cnt_reg + 64'd1;
        end
    end

    assign out_commit_cnt = commit_cnt_reg;
`else
    assign out_commit_cnt = 64'd0;
`endif

endmodule

// File: doc/diff_commit_queue.md
DIFF_COMMIT_QUEUE -- requirements
Module: diff_commit_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entry count (power of two, 2..16).
REQ-002 SHALL have parameter PTR_W, default 2, log2(DEPTH).
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  writeback stage presents a retired-instruction record.
REQ-006 SHALL have port in_ready  output  1  queue accepts a record this cycle.
REQ-007 SHALL have ports in_pc/in_instr/in_skip/in_wen/in_wdest/in_wdata  input  64/32/1/1/8/64  commit payload.
REQ-008 SHALL have ports in_store_valid/in_store_paddr/in_store_data  input  8/64/64  store payload of the same record.
REQ-009 SHALL have port in_halt  input  1  record is the trap/ebreak terminating the run.
REQ-010 SHALL have port out_en  input  1  difftest side may consume one record this cycle.
REQ-011 SHALL have port out_instr_valid  output  1  record presented to instruction-commit and store-event checkers.
REQ-012 SHALL have port out_index  output  8  commit slot index.
REQ-013 SHALL have ports out_pc/out_instr/out_skip/out_wen/out_wdest/out_wdata/out_store_valid/out_store_paddr/out_store_data  output  same widths as in_*  registered payload.
REQ-014 SHALL have port out_halt  output  1  sticky halt-reached flag.
REQ-015 SHALL have port out_overflow  output  1  sticky flag: push attempted while full.
REQ-016 SHALL have port out_commit_cnt  output  64  total records emitted.

Function
REQ-017 SHALL push a record when in_valid && in_ready; in_ready = !full && state != HALT.
REQ-018 SHALL pop the head when queue non-empty, out_en=1 and state==RUN; the popped record appears on out_* with out_instr_valid=1 exactly on the next cycle, for one cycle only.
REQ-019 SHALL hold out_instr_valid=0 and out_store_valid=0 in cycles with no pop; payload outputs keep their last value.
REQ-020 SHALL support simultaneous push and pop in one cycle, including when full (in_ready stays 0 when full, so a push and pop never coincide at full) and when empty (the record is not popped in its push cycle; minimum in-to-out latency is 2 cycles).
REQ-021 SHALL maintain count 0..DEPTH with wrapping read/write pointers of PTR_W bits; full = (count==DEPTH), empty = (count==0).
REQ-022 SHALL increment out_index by 1 per pop, modulo 256 (255 -> 0), reflecting the emitted record.
REQ-023 SHALL set out_overflow when in_valid=1 and full; it clears only on reset; the offered record is dropped.
REQ-024 SHALL implement states RUN and HALT: RUN -> HALT on the cycle a record with in_halt=1 is popped; HALT is absorbing until reset.
REQ-025 SHALL in HALT stop all pushes and pops, keep out_halt=1, and discard remaining queued entries.
REQ-026 SHALL force out_wen=0 on output whenever out_wdest==0 (x0 write suppression).

Reset
REQ-027 SHALL on reset clear count, pointers, out_index, out_commit_cnt, out_overflow, out_halt, all out_* payload to 0, and enter RUN.
REQ-028 SHALL honour reset mid-operation: queued records are lost; in_ready=1 on the first cycle after reset deasserts.

Configuration
REQ-029 SHALL, with DIFF_COMMIT_CNT_EN defined, increment out_commit_cnt by 1 per pop (64-bit wrap).
REQ-030 SHALL, without DIFF_COMMIT_CNT_EN, tie out_commit_cnt to 0 and implement no counter register.

Verification
REQ-031 SHALL cover: single push pc=0x80000000, out_en=1 -> out_instr_valid=1 two cycles later, out_pc=0x80000000, out_index=0.
REQ-032 SHALL cover: out_en=0, 5 pushes at DEPTH=4 -> in_ready=0 after 4th, out_overflow=1, then out_en=1 drains exactly 4 records in order.
REQ-033 SHALL cover: 257 back-to-back records, out_en=1 -> out_index sequence 0..255,0; out_commit_cnt=257 with DIFF_COMMIT_CNT_EN, 0 without.
REQ-034 SHALL cover: record with in_halt=1 followed by 2 queued records -> out_halt=1 the cycle after halt pops, no further out_instr_valid, in_ready=0.
REQ-035 SHALL cover: record in_wen=1, in_wdest=0, in_wdata=0x5 -> emitted out_wen=0.
REQ-036 SHALL cover: reset asserted with 3 entries queued -> all outputs 0, in_ready=1 next cycle, no out_instr_valid from stale entries.
